vga_bounce_gen: RTL and testbench

VGA_BOUNCE_GEN -- requirements
Module: vga_bounce_gen

---
 rtl/vga_pkg.sv | 28 ++
 rtl/vga_bounce_gen_if.sv | 22 ++
 rtl/vga_timing.sv | 75 +++++++
 rtl/vga_bounce_gen.sv | 175 +++++++++++++++++
 tb/tb_vga_bounce_gen.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA constants: 640x480@60 timing defaults, transparent colour key,
// background bar palette and the sprite direction type.
package vga_pkg;

    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BACK_DEF   = 48;
    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FRONT_DEF  = 16;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BACK_DEF   = 33;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FRONT_DEF  = 10;
    localparam bit          SYNC_POL_DEF = 1'b0;

    // Sprite texels equal to this value show the background instead.
    localparam logic [7:0] TRANSPARENT_KEY = 8'h00;

    // Bar colours {r[2:0],g[2:0],b[1:0]}; element 0 is the topmost bar.
    localparam logic [7:0][7:0] BAR_LUT = {
        8'h92, 8'hFF, 8'hE3, 8'h1F, 8'hFC, 8'h03, 8'h1C, 8'hE0
    };

    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_e;

endpackage

// File: rtl/vga_bounce_gen_if.sv
// Video output and sprite ROM port of vga_bounce_gen.
// master = generator side, slave = display/ROM side.
interface vga_bounce_gen_if #(
    parameter int unsigned ADDR_W = 12
);
    logic [ADDR_W-1:0] spr_addr;
    logic [7:0]        spr_data;
    logic              h_sync;
    logic              v_sync;
    logic              de;
    logic [7:0]        rgb;

    modport master (
        output spr_addr, h_sync, v_sync, de, rgb,
        input  spr_data
    );

    modport slave (
        input  spr_addr, h_sync, v_sync, de, rgb,
        output spr_data
    );
endinterface

// File: rtl/vga_timing.sv
// Raster counters with combinational sync, active-video and pixel-coordinate
// decode. px/py read 0 outside the active region.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BACK   = H_BACK_DEF,
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FRONT  = H_FRONT_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BACK   = V_BACK_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FRONT  = V_FRONT_DEF,
    parameter bit          SYNC_POL = SYNC_POL_DEF,
    parameter int unsigned PW       = 10
) (
    input  logic          vga_clk,
    input  logic          rst_n,
    output logic          h_sync_o,
    output logic          v_sync_o,
    output logic          de_o,
    output logic          frame_start_o,
    output logic [PW-1:0] px_o,
    output logic [PW-1:0] py_o
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int unsigned H_START = H_SYNC + H_BACK;
    localparam int unsigned V_START = V_SYNC + V_BACK;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic          h_act, v_act;

    // Next raster position: h wraps every line, v advances on h wrap.
    always_comb begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == HW'(H_TOTAL - 1)) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == VW'(V_TOTAL - 1)) ? '0 : v_cnt_q + 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Sync/active decode; offsets are only formed inside the active window.
    always_comb begin
        h_act         = (32'(h_cnt_q) >= H_START) && (32'(h_cnt_q) < H_START + H_ACTIVE);
        v_act         = (32'(v_cnt_q) >= V_START) && (32'(v_cnt_q) < V_START + V_ACTIVE);
        h_sync_o      = (32'(h_cnt_q) < H_SYNC) ? SYNC_POL : ~SYNC_POL;
        v_sync_o      = (32'(v_cnt_q) < V_SYNC) ? SYNC_POL : ~SYNC_POL;
        de_o          = h_act && v_act;
        frame_start_o = (h_cnt_q == '0) && (v_cnt_q == '0);
        px_o          = '0;
        py_o          = '0;
        if (de_o) begin
            px_o = PW'(32'(h_cnt_q) - H_START);
            py_o = PW'(32'(v_cnt_q) - V_START);
        end
    end

endmodule

// File: rtl/vga_bounce_gen.sv
// Bouncing-sprite test pattern: a SPR_W x SPR_H ROM sprite moving over
// NUM_BARS horizontal colour bars. Two-stage pipeline: stage 1 registers the
// ROM address and in-sprite flag, the external ROM answers during the
// following cycle, stage 2 registers rgb. Sync and de are delayed to match.
module vga_bounce_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_SYNC      = H_SYNC_DEF,
    parameter int unsigned H_BACK      = H_BACK_DEF,
    parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
    parameter int unsigned H_FRONT     = H_FRONT_DEF,
    parameter int unsigned V_SYNC      = V_SYNC_DEF,
    parameter int unsigned V_BACK      = V_BACK_DEF,
    parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
    parameter int unsigned V_FRONT     = V_FRONT_DEF,
    parameter bit          SYNC_POL    = SYNC_POL_DEF,
    parameter int unsigned SPR_W       = 64,
    parameter int unsigned SPR_H       = 64,
    parameter int unsigned STEP_FRAMES = 1,
    parameter int unsigned NUM_BARS    = 3
) (
    input  logic             vga_clk,
    input  logic             rst_n,
    input  logic             move_en,
    vga_bounce_gen_if.master bus
);

    localparam int unsigned PW = $clog2(((H_ACTIVE > V_ACTIVE) ? H_ACTIVE : V_ACTIVE) + 1);
    localparam int unsigned AW = $clog2(SPR_W * SPR_H);
    localparam int unsigned FW = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;

    logic          hs_t, vs_t, de_t, frame_start;
    logic [PW-1:0] px, py;

    logic [PW-1:0] spr_x_q, spr_x_d, spr_y_q, spr_y_d;
    dir_e          dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic [FW-1:0] fcnt_q, fcnt_d;

    logic [AW-1:0] spr_addr_q, spr_addr_d;
    logic          in_spr_q, in_spr_d;
    logic [7:0]    bar_q, bar_d;
    logic          hs1_q, vs1_q, de1_q;
    logic [7:0]    rgb_q, rgb_d;
    logic          hs2_q, vs2_q, de2_q;

    vga_timing #(
        .H_SYNC  (H_SYNC),
        .H_BACK  (H_BACK),
        .H_ACTIVE(H_ACTIVE),
        .H_FRONT (H_FRONT),
        .V_SYNC  (V_SYNC),
        .V_BACK  (V_BACK),
        .V_ACTIVE(V_ACTIVE),
        .V_FRONT (V_FRONT),
        .SYNC_POL(SYNC_POL),
        .PW      (PW)
    ) u_timing (
        .vga_clk      (vga_clk),
        .rst_n        (rst_n),
        .h_sync_o     (hs_t),
        .v_sync_o     (vs_t),
        .de_o         (de_t),
        .frame_start_o(frame_start),
        .px_o         (px),
        .py_o         (py)
    );

    // Sprite motion: one pixel per axis every STEP_FRAMES enabled frames;
    // at an edge the direction flips and the same step moves back one pixel.
    always_comb begin
        spr_x_d = spr_x_q;
        spr_y_d = spr_y_q;
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        fcnt_d  = fcnt_q;
        if (frame_start && move_en) begin
            if (fcnt_q == FW'(STEP_FRAMES - 1)) begin
                fcnt_d = '0;
                if (dir_x_q == DIR_POS) begin
                    if (spr_x_q == PW'(H_ACTIVE - SPR_W)) begin
                        dir_x_d = DIR_NEG;
                        spr_x_d = spr_x_q - 1'b1;
                    end else begin
                        spr_x_d = spr_x_q + 1'b1;
                    end
                end else if (spr_x_q == '0) begin
                    dir_x_d = DIR_POS;
                    spr_x_d = spr_x_q + 1'b1;
                end else begin
                    spr_x_d = spr_x_q - 1'b1;
                end
                if (dir_y_q == DIR_POS) begin
                    if (spr_y_q == PW'(V_ACTIVE - SPR_H)) begin
                        dir_y_d = DIR_NEG;
                        spr_y_d = spr_y_q - 1'b1;
                    end else begin
                        spr_y_d = spr_y_q + 1'b1;
                    end
                end else if (spr_y_q == '0) begin
                    dir_y_d = DIR_POS;
                    spr_y_d = spr_y_q + 1'b1;
                end else begin
                    spr_y_d = spr_y_q - 1'b1;
                end
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    // Stage 1 decode: sprite hit test before offset subtraction, bar lookup.
    always_comb begin
        in_spr_d   = 1'b0;
        spr_addr_d = '0;
        if (de_t
            && (32'(px) >= 32'(spr_x_q)) && (32'(px) < 32'(spr_x_q) + SPR_W)
            && (32'(py) >= 32'(spr_y_q)) && (32'(py) < 32'(spr_y_q) + SPR_H)) begin
            in_spr_d   = 1'b1;
            spr_addr_d = AW'((32'(py) - 32'(spr_y_q)) * SPR_W + (32'(px) - 32'(spr_x_q)));
        end
        bar_d = BAR_LUT[3'((32'(py) * NUM_BARS) / V_ACTIVE)];
    end

    // Stage 2 colour select: opaque sprite texel over bar, black when blanked.
    always_comb begin
        rgb_d = '0;
        if (de1_q) begin
            rgb_d = (in_spr_q && (bus.spr_data != TRANSPARENT_KEY)) ? bus.spr_data : bar_q;
        end
    end

    // Motion state and both pipeline stages.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            spr_x_q    <= '0;
            spr_y_q    <= '0;
            dir_x_q    <= DIR_POS;
            dir_y_q    <= DIR_POS;
            fcnt_q     <= '0;
            spr_addr_q <= '0;
            in_spr_q   <= 1'b0;
            bar_q      <= '0;
            hs1_q      <= ~SYNC_POL;
            vs1_q      <= ~SYNC_POL;
            de1_q      <= 1'b0;
            rgb_q      <= '0;
            hs2_q      <= ~SYNC_POL;
            vs2_q      <= ~SYNC_POL;
            de2_q      <= 1'b0;
        end else begin
            spr_x_q    <= spr_x_d;
            spr_y_q    <= spr_y_d;
            dir_x_q    <= dir_x_d;
            dir_y_q    <= dir_y_d;
            fcnt_q     <= fcnt_d;
            spr_addr_q <= spr_addr_d;
            in_spr_q   <= in_spr_d;
            bar_q      <= bar_d;
            hs1_q      <= hs_t;
            vs1_q      <= vs_t;
            de1_q      <= de_t;
            rgb_q      <= rgb_d;
            hs2_q      <= hs1_q;
            vs2_q      <= vs1_q;
            de2_q      <= de1_q;
        end
    end

    assign bus.spr_addr = spr_addr_q;
    assign bus.h_sync   = hs2_q;
    assign bus.v_sync   = vs2_q;
    assign bus.de       = de2_q;
    assign bus.rgb      = rgb_q;

endmodule

// File: tb/tb_vga_bounce_gen.sv
// Directed bench for vga_bounce_gen on a shrunken raster (23 x 16, 16x12
// visible) with a 4x4 sprite stepping every 2 frames. ROM texel = 0x80|addr,
// except address 5 which is transparent.
`timescale 1ns/1ps
module tb_vga_bounce_gen;

    localparam int HS = 2, HB = 3, HA = 16, HF = 2;
    localparam int VS = 1, VB = 2, VA = 12, VF = 1;
    localparam int SW = 4, SH = 4;
    localparam int BUDGET = 2000;

    logic vga_clk = 1'b0;
    logic rst_n   = 1'b0;
    logic move_en = 1'b0;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    vga_bounce_gen_if #(.ADDR_W(4)) bus ();

    vga_bounce_gen #(
        .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
        .SYNC_POL(1'b0), .SPR_W(SW), .SPR_H(SH),
        .STEP_FRAMES(2), .NUM_BARS(3)
    ) dut (
        .vga_clk(vga_clk),
        .rst_n  (rst_n),
        .move_en(move_en),
        .bus    (bus)
    );

    always #5 vga_clk = ~vga_clk;

    // Sprite ROM: answers the registered address within the same cycle.
    assign bus.spr_data = (bus.spr_addr == 4'd5) ? 8'h00 : {4'h8, bus.spr_addr};

    // Frame index: counts v_sync assertions seen at the outputs since reset.
    int   frame_no = -1;
    logic vs_prev  = 1'b1;
    always @(negedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_no <= -1;
            vs_prev  <= 1'b1;
        end else begin
            vs_prev <= bus.v_sync;
            if (vs_prev && !bus.v_sync) frame_no <= frame_no + 1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference motion model (state as of the latest frame start).
    int mx = 0, my = 0, mfc = 0;
    bit mdx = 1'b0, mdy = 1'b0;   // 0 = moving +

    task automatic model_reset();
        mx = 0; my = 0; mfc = 0; mdx = 1'b0; mdy = 1'b0;
    endtask

    task automatic model_frame_start(input bit en);
        if (!en) return;
        if (mfc != 1) begin
            mfc++;
            return;
        end
        mfc = 0;
        if (!mdx) begin
            if (mx == HA - SW) begin mdx = 1'b1; mx--; end else mx++;
        end else begin
            if (mx == 0) begin mdx = 1'b0; mx++; end else mx--;
        end
        if (!mdy) begin
            if (my == VA - SH) begin mdy = 1'b1; my--; end else my++;
        end else begin
            if (my == 0) begin mdy = 1'b0; my++; end else my--;
        end
    endtask

    // Expected colour of visible pixel (x,y) with the sprite at (sx,sy).
    function automatic logic [7:0] exp_pix(int x, int y, int sx, int sy);
        int a;
        if (x >= sx && x < sx + SW && y >= sy && y < sy + SH) begin
            a = (y - sy) * SW + (x - sx);
            if (a != 5) return 8'h80 | 8'(a);
        end
        // 3 bars over 12 lines: bar = y*3/12
        case ((y * 3) / 12)
            0:       return 8'hE0;
            1:       return 8'h1C;
            default: return 8'h03;
        endcase
    endfunction

    logic [7:0] pix [VA][HA];
    int obs_x [64];
    int obs_y [64];

    // Capture the visible area of frame f; report the sprite's top-left.
    task automatic scan_frame(input int f, output int sx, output int sy);
        int   budget, row, col, lines;
        logic prev;
        for (int y = 0; y < VA; y++)
            for (int x = 0; x < HA; x++) pix[y][x] = 8'h00;
        budget = 0;
        while (frame_no != f && budget < BUDGET) begin
            @(negedge vga_clk);
            budget++;
        end
        row = -1; col = 0; lines = 0; prev = 1'b0; sx = -1; sy = -1;
        while (lines < VA && budget < BUDGET) begin
            @(negedge vga_clk);
            budget++;
            if (bus.de && !prev) begin row++; col = 0; end
            if (bus.de) begin
                if (row >= 0 && row < VA && col < HA) begin
                    pix[row][col] = bus.rgb;
                    if (sx < 0 && bus.rgb[7:4] == 4'h8) begin sx = col; sy = row; end
                end
                col++;
            end
            if (!bus.de && prev) lines++;
            prev = bus.de;
        end
        check($sformatf("frame %0d active lines", f), lines, VA);
    endtask

    task automatic run_frame(input int f);
        int sx, sy, bad;
        model_frame_start(move_en);
        scan_frame(f, sx, sy);
        obs_x[f] = sx;
        obs_y[f] = sy;
        check($sformatf("frame %0d spr_x", f), sx, mx);
        check($sformatf("frame %0d spr_y", f), sy, my);
        bad = 0;
        for (int y = 0; y < VA; y++)
            for (int x = 0; x < HA; x++)
                if (pix[y][x] !== exp_pix(x, y, mx, my)) bad++;
        check($sformatf("frame %0d bad pixels", f), bad, 0);
    endtask

    task automatic check_reset_outputs(input string when);
        check({when, " h_sync"},   bus.h_sync,   1);
        check({when, " v_sync"},   bus.v_sync,   1);
        check({when, " de"},       bus.de,       0);
        check({when, " rgb"},      bus.rgb,      0);
        check({when, " spr_addr"}, bus.spr_addr, 0);
    endtask

    initial begin
        int n, hs_low, hs_high, vs_low, vs_high, hsl, vsl, deh, budget;

        move_en = 1'b1;
        repeat (3) @(negedge vga_clk);
        check_reset_outputs("reset");

        // Release and time the first sync edges and first active pixel.
        rst_n = 1'b1;
        n = 0; hs_low = -1; hs_high = -1; vs_low = -1; vs_high = -1;
        while (!bus.de && n < 1000) begin
            if (hs_low < 0 && !bus.h_sync) hs_low = n;
            if (hs_low >= 0 && hs_high < 0 && bus.h_sync) hs_high = n;
            if (vs_low < 0 && !bus.v_sync) vs_low = n;
            if (vs_low >= 0 && vs_high < 0 && bus.v_sync) vs_high = n;
            @(negedge vga_clk);
            n++;
        end
        // (VS+VB)*23 + HS+HB + 2 = 3*23 + 5 + 2
        check("first de cycle", n, 76);
        check("first h_sync low", hs_low, 2);
        check("first h_sync high", hs_high, 4);
        check("first v_sync low", vs_low, 2);
        check("first v_sync high", vs_high, 25);

        // Frame 0 is partly consumed above; account for its start only.
        model_frame_start(move_en);
        for (int f = 1; f <= 51; f++) begin
            run_frame(f);
            if (f == 1) begin
                // sprite at (1,1)
                check("f1 pix(0,0) bar0", pix[0][0], 8'hE0);
                check("f1 pix(1,1) texel0", pix[1][1], 8'h80);
                check("f1 pix(4,1) texel3", pix[1][4], 8'h83);
                check("f1 pix(2,2) transparent", pix[2][2], 8'hE0);
                check("f1 pix(4,4) texel15", pix[4][4], 8'h8F);
                check("f1 pix(5,5) bar1", pix[5][5], 8'h1C);
                check("f1 pix(15,11) bar2", pix[11][15], 8'h03);
            end
        end
        check("x at right edge", obs_x[23], 12);
        check("x after right bounce", obs_x[25], 11);
        check("y at bottom edge", obs_y[15], 8);
        check("y after bottom bounce", obs_y[17], 7);
        check("x at left edge", obs_x[47], 0);
        check("y before corner", obs_y[47], 8);
        check("corner x", obs_x[49], 1);
        check("corner y", obs_y[49], 7);

        // Hold for 10 frames, then resume.
        move_en = 1'b0;
        for (int f = 52; f <= 61; f++) run_frame(f);
        check("hold x", obs_x[61], 2);
        check("hold y", obs_y[61], 6);
        move_en = 1'b1;
        run_frame(62);
        run_frame(63);
        check("resume no step x", obs_x[62], 2);
        check("resume step x", obs_x[63], 3);
        check("resume step y", obs_y[63], 5);

        // One full frame period of output activity.
        hsl = 0; vsl = 0; deh = 0;
        repeat (23 * 16) begin
            @(negedge vga_clk);
            if (!bus.h_sync) hsl++;
            if (!bus.v_sync) vsl++;
            if (bus.de) deh++;
        end
        check("h_sync low per frame", hsl, 32);
        check("v_sync low per frame", vsl, 23);
        check("de high per frame", deh, 192);

        // Asynchronous reset in the middle of an active line.
        budget = 0;
        while (!bus.de && budget < BUDGET) begin
            @(negedge vga_clk);
            budget++;
        end
        @(negedge vga_clk);
        check("de before mid-line reset", bus.de, 1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid-line reset");
        repeat (3) @(negedge vga_clk);
        model_reset();
        rst_n = 1'b1;
        run_frame(0);
        check("post-reset x", obs_x[0], 0);
        check("post-reset y", obs_y[0], 0);
        check("post-reset pix(0,0)", pix[0][0], 8'h80);
        run_frame(1);
        check("post-reset step x", obs_x[1], 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
